// File: rtl/flag_progress_animated_if.sv
// Video-side signal bundle for flag_progress_animated.
//   pix_x, pix_y  : current pixel column / row (0..639, 0..479 active)
//   display_on    : high during active video
//   frame_start   : one-cycle pulse per frame, during blanking
//   color         : registered RRGGBB pixel colour from the renderer
// master = video timing source, slave = renderer.
interface flag_progress_animated_if;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       display_on;
  logic       frame_start;
  logic [5:0] color;

  modport master (
    output pix_x, pix_y, display_on, frame_start,
    input  color
  );

  modport slave (
    input  pix_x, pix_y, display_on, frame_start,
    output color
  );
endinterface

// File: rtl/flag_progress_animated.sv
// Animated progress-pride flag renderer.
// The chevron stack retracts to the left by up to SHIFT_MAX pixels and
// extends back, resting fully extended for HOLD_FRAMES frames each cycle.
// Ports:
//   clk  : pixel clock
//   rst  : asynchronous active-high reset
//   vid  : flag_progress_animated_if.slave (pixel position, display_on,
//          frame_start in; registered colour out, latency 1)
// Build option: define FLAG_PROGRESS_CIRCLE_EN to draw the purple ring in
// the inner field; otherwise the inner field is solid yellow.
module flag_progress_animated #(
  parameter int unsigned CHEVRON_W   = 60,
  parameter int unsigned HOLD_FRAMES = 120,
  parameter int unsigned STEP        = 2,
  parameter int unsigned SHIFT_MAX   = 300
) (
  input logic                     clk,
  input logic                     rst,
  flag_progress_animated_if.slave vid
);

  // Shared flag palette, RRGGBB.
  localparam logic [5:0] RED    = 6'b110000;
  localparam logic [5:0] ORANGE = 6'b111000;
  localparam logic [5:0] YELLOW = 6'b111100;
  localparam logic [5:0] GREEN  = 6'b001100;
  localparam logic [5:0] BLUE   = 6'b000011;
  localparam logic [5:0] PURPLE = 6'b100010;
  localparam logic [5:0] WHITE  = 6'b111111;
  localparam logic [5:0] PINK   = 6'b111011;
  localparam logic [5:0] LTBLUE = 6'b011111;
  localparam logic [5:0] BROWN  = 6'b100100;
  localparam logic [5:0] BLACK  = 6'b000000;

  localparam logic signed [11:0] W1 = 12'(CHEVRON_W);
  localparam logic signed [11:0] W2 = 12'(2 * CHEVRON_W);
  localparam logic signed [11:0] W3 = 12'(3 * CHEVRON_W);
  localparam logic signed [11:0] W4 = 12'(4 * CHEVRON_W);

  typedef enum logic [1:0] {StHold, StRetract, StExtend} state_e;

  state_e     r_state;
  logic [8:0] r_shift;
  logic [7:0] r_hold_cnt;
  logic [5:0] r_color;

  logic signed [11:0] w_ty;
  logic signed [11:0] w_d;
  logic [9:0]         w_up;
  logic [5:0]         w_inner;
  logic [5:0]         w_color;

  // Mirror the lower half so the chevrons point right.
  assign w_ty = (vid.pix_y < 10'd240) ? $signed({2'b00, vid.pix_y})
                                      : 12'sd479 - $signed({2'b00, vid.pix_y});
  assign w_d  = $signed({2'b00, vid.pix_x}) + $signed({3'b000, r_shift}) - w_ty;
  assign w_up = {1'b0, r_shift} + 10'(STEP);

`ifdef FLAG_PROGRESS_CIRCLE_EN
  logic signed [11:0] w_cxs;
  logic [10:0]        w_cx;
  logic [9:0]         w_cy;
  logic [21:0]        w_r2;

  // Circle centre tracks the chevrons: x = 70 - shift, y = 240.
  assign w_cxs = $signed({2'b00, vid.pix_x}) - 12'sd70 + $signed({3'b000, r_shift});
  assign w_cx  = w_cxs[11] ? 11'(-w_cxs) : w_cxs[10:0];
  assign w_cy  = (vid.pix_y >= 10'd240) ? vid.pix_y - 10'd240 : 10'd240 - vid.pix_y;
  assign w_r2  = 22'(w_cx) * 22'(w_cx) + 22'(w_cy) * 22'(w_cy);

  always_comb begin
    w_inner = YELLOW;
    if (w_r2 >= 22'd2000 && w_r2 < 22'd3000) w_inner = PURPLE;
  end
`else
  assign w_inner = YELLOW;
`endif

  always_comb begin
    w_color = BLACK;
    if (w_d < -W1)      w_color = w_inner;
    else if (w_d < 0)   w_color = WHITE;
    else if (w_d < W1)  w_color = PINK;
    else if (w_d < W2)  w_color = LTBLUE;
    else if (w_d < W3)  w_color = BROWN;
    else if (w_d < W4)  w_color = BLACK;
    else if (vid.pix_y < 10'd80)  w_color = RED;
    else if (vid.pix_y < 10'd160) w_color = ORANGE;
    else if (vid.pix_y < 10'd240) w_color = YELLOW;
    else if (vid.pix_y < 10'd320) w_color = GREEN;
    else if (vid.pix_y < 10'd400) w_color = BLUE;
    else                          w_color = PURPLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_color <= 6'b000000;
    end else begin
      r_color <= vid.display_on ? w_color : 6'b000000;
    end
  end

  assign vid.color = r_color;

  // Animation advances once per frame; saturating steps keep shift in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StHold;
      r_shift    <= 9'd0;
      r_hold_cnt <= 8'd0;
    end else if (vid.frame_start) begin
      unique case (r_state)
        StHold: begin
          r_shift <= 9'd0;
          if (r_hold_cnt == 8'(HOLD_FRAMES - 1)) begin
            r_hold_cnt <= 8'd0;
            r_state    <= StRetract;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        StRetract: begin
          if (w_up >= 10'(SHIFT_MAX)) begin
            r_shift <= 9'(SHIFT_MAX);
            r_state <= StExtend;
          end else begin
            r_shift <= w_up[8:0];
          end
        end
        StExtend: begin
          if (r_shift <= 9'(STEP)) begin
            r_shift    <= 9'd0;
            r_hold_cnt <= 8'd0;
            r_state    <= StHold;
          end else begin
            r_shift <= r_shift - 9'(STEP);
          end
        end
        default: begin
          r_state    <= StHold;
          r_shift    <= 9'd0;
          r_hold_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_progress_animated.sv
// Randomized bench for flag_progress_animated against a frame-count model.
module tb_flag_progress_animated;

  localparam int W       = 60;
  localparam int HOLD    = 120;
  localparam int STEPV   = 2;
  localparam int SMAX    = 300;
  localparam int NRAMP   = SMAX / STEPV;
  localparam int PERIOD  = HOLD + 2 * NRAMP;

  localparam logic [5:0] C_RED    = 6'b110000;
  localparam logic [5:0] C_ORANGE = 6'b111000;
  localparam logic [5:0] C_YELLOW = 6'b111100;
  localparam logic [5:0] C_GREEN  = 6'b001100;
  localparam logic [5:0] C_BLUE   = 6'b000011;
  localparam logic [5:0] C_PURPLE = 6'b100010;
  localparam logic [5:0] C_WHITE  = 6'b111111;
  localparam logic [5:0] C_PINK   = 6'b111011;
  localparam logic [5:0] C_LTBLUE = 6'b011111;
  localparam logic [5:0] C_BROWN  = 6'b100100;
  localparam logic [5:0] C_BLACK  = 6'b000000;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   frames;

  flag_progress_animated_if vid_if ();

  flag_progress_animated #(
    .CHEVRON_W  (W),
    .HOLD_FRAMES(HOLD),
    .STEP       (STEPV),
    .SHIFT_MAX  (SMAX)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .vid(vid_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (frames=%0d)", tag, got, exp, frames);
    end
  endtask

  // Shift after n frame pulses since reset: hold, ramp up, ramp down, repeat.
  function automatic int shift_of(input int n);
    int p;
    p = n % PERIOD;
    if (p <= HOLD) return 0;
    if (p <= HOLD + NRAMP) return STEPV * (p - HOLD);
    return STEPV * (PERIOD - p);
  endfunction

  function automatic logic [5:0] model_color(input int x, input int y, input bit on,
                                             input int sh);
    int ty;
    int d;
    int s;
    int cx;
    int cy;
    int r2;
    if (!on) return C_BLACK;
    ty = (y < 240) ? y : 479 - y;
    d  = x + sh - ty;
    if (d < -W) begin
`ifdef FLAG_PROGRESS_CIRCLE_EN
      cx = x - (70 - sh);
      if (cx < 0) cx = -cx;
      cy = y - 240;
      if (cy < 0) cy = -cy;
      r2 = cx * cx + cy * cy;
      if (r2 < 2000) return C_YELLOW;
      if (r2 < 3000) return C_PURPLE;
      return C_YELLOW;
`else
      cx = 0; cy = 0; r2 = 0;
      return C_YELLOW;
`endif
    end
    if (d < 0)     return C_WHITE;
    if (d < W)     return C_PINK;
    if (d < 2 * W) return C_LTBLUE;
    if (d < 3 * W) return C_BROWN;
    if (d < 4 * W) return C_BLACK;
    s = y / 80;
    case (s)
      0: return C_RED;
      1: return C_ORANGE;
      2: return C_YELLOW;
      3: return C_GREEN;
      4: return C_BLUE;
      default: return C_PURPLE;
    endcase
  endfunction

  // Drive one cycle and check the colour it produces against the model.
  task automatic drive(input string tag, input int x, input int y, input bit on, input bit fs);
    logic [5:0] exp;
    @(negedge clk);
    vid_if.pix_x       = 10'(x);
    vid_if.pix_y       = 10'(y);
    vid_if.display_on  = on;
    vid_if.frame_start = fs;
    exp = model_color(x, y, on, shift_of(frames));
    if (fs) frames++;
    @(posedge clk);
    #1;
    check_eq(tag, 32'(vid_if.color), 32'(exp));
  endtask

  task automatic run_random(input int target, input int budget);
    int  cyc;
    int  x;
    int  y;
    bit  on;
    bit  fs;
    cyc = 0;
    while (frames < target && cyc < budget) begin
      x  = $urandom_range(0, 700);
      y  = ($urandom_range(0, 15) == 0) ? $urandom_range(480, 1023) : $urandom_range(0, 479);
      on = ($urandom_range(0, 9) != 0);
      fs = ($urandom_range(0, 2) == 0);
      drive("rand", x, y, on, fs);
      cyc++;
    end
    check_eq("frame_budget", 32'(frames), 32'(target));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    frames  = 0;
    rst = 1'b1;
    vid_if.pix_x       = '0;
    vid_if.pix_y       = '0;
    vid_if.display_on  = 1'b1;
    vid_if.frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_color", 32'(vid_if.color), 32'(C_BLACK));
    @(negedge clk);
    rst = 1'b0;

    // Directed points at shift = 0.
    drive("edge_yellow", 0, 240, 1'b1, 1'b0);
    check_eq("edge_yellow_k", 32'(vid_if.color), 32'(C_YELLOW));
    drive("pink", 30, 0, 1'b1, 1'b0);
    check_eq("pink_k", 32'(vid_if.color), 32'(C_PINK));
    drive("red", 250, 0, 1'b1, 1'b0);
    check_eq("red_k", 32'(vid_if.color), 32'(C_RED));
    drive("purple", 250, 479, 1'b1, 1'b0);
    check_eq("purple_k", 32'(vid_if.color), 32'(C_PURPLE));
    drive("row_over", 600, 700, 1'b1, 1'b0);
    check_eq("row_over_k", 32'(vid_if.color), 32'(C_PURPLE));
    drive("blank", 250, 0, 1'b0, 1'b0);
    check_eq("blank_k", 32'(vid_if.color), 32'(C_BLACK));

    // Exactly HOLD pulses keeps shift at 0; the next one moves it by STEP.
    for (int i = 0; i < HOLD; i++) drive("hold", 30, 0, 1'b1, 1'b1);
    drive("hold_end", 59, 0, 1'b1, 1'b0);
    check_eq("hold_end_k", 32'(vid_if.color), 32'(C_PINK));
    drive("first_step", 59, 0, 1'b1, 1'b1);
    drive("after_step", 59, 0, 1'b1, 1'b0);
    check_eq("after_step_k", 32'(vid_if.color), 32'(C_LTBLUE));

    // Random run up to shift = 100 while retracting, then reset mid-animation.
    run_random(HOLD + 50, 2000);
    @(negedge clk);
    vid_if.display_on  = 1'b1;
    vid_if.pix_x       = 10'd250;
    vid_if.pix_y       = 10'd0;
    vid_if.frame_start = 1'b1;
    #2 rst = 1'b1;
    #1 check_eq("async_rst_color", 32'(vid_if.color), 32'(C_BLACK));
    @(posedge clk);
    #1 check_eq("rst_hold_color", 32'(vid_if.color), 32'(C_BLACK));
    @(negedge clk);
    vid_if.frame_start = 1'b0;
    rst    = 1'b0;
    frames = 0;
    drive("post_rst", 30, 0, 1'b1, 1'b0);
    check_eq("post_rst_k", 32'(vid_if.color), 32'(C_PINK));

    // Two full animation periods, covering both saturation points.
    run_random(2 * PERIOD, 6000);

`ifdef FLAG_PROGRESS_CIRCLE_EN
    drive("circ_center", 70, 240, 1'b1, 1'b0);
    check_eq("circ_center_k", 32'(vid_if.color), 32'(C_YELLOW));
    drive("circ_ring", 70, 290, 1'b1, 1'b0);
    check_eq("circ_ring_k", 32'(vid_if.color), 32'(C_PURPLE));
`else
    drive("field", 70, 290, 1'b1, 1'b0);
    check_eq("field_k", 32'(vid_if.color), 32'(C_YELLOW));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/flag_progress_animated.md
FLAG_PROGRESS_ANIMATED -- requirements
Module: flag_progress_animated

Interface
REQ-001 Parameter CHEVRON_W, default 60: width in pixels of each chevron band.
REQ-002 Parameter HOLD_FRAMES, default 120: frames the flag rests fully extended.
REQ-003 Parameter STEP, default 2: chevron shift change per frame while animating.
REQ-004 Parameter SHIFT_MAX, default 300: maximum chevron retraction in pixels; SHIFT_MAX SHALL be a multiple of STEP.
REQ-005 clk  input  1  pixel clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 pix_x  input  10  current pixel column, 0..639 active.
REQ-008 pix_y  input  10  current pixel row, 0..479 active.
REQ-009 display_on  input  1  high during active video.
REQ-010 frame_start  input  1  single-cycle pulse once per frame, during blanking.
REQ-011 color  output  6  RRGGBB pixel colour, encoded with the shared colour constants in flag.vh.

Function
REQ-012 color SHALL be registered; it reflects pix_x, pix_y, display_on and shift from the previous cycle (latency 1).
REQ-013 When display_on was low, color SHALL be 6'b000000.
REQ-014 Mirrored row: ty = pix_y if pix_y < 240, else 479 - pix_y; offset d = pix_x + shift - ty, computed signed 12-bit without overflow.
REQ-015 Region by d: d < -CHEVRON_W inner field; d < 0 WHITE; d < W PINK; d < 2W LTBLUE; d < 3W BROWN; d < 4W BLACK; else rainbow (W = CHEVRON_W).
REQ-016 Rainbow: six 80-row stripes by pix_y: RED, ORANGE, YELLOW, GREEN, BLUE, PURPLE, top to bottom; rows >= 480 SHALL use PURPLE.
REQ-017 Animation FSM states: HOLD, RETRACT, EXTEND; the FSM, shift (9 bit) and hold_cnt (8 bit) SHALL update only on cycles with frame_start high.
REQ-018 HOLD: shift = 0; hold_cnt increments; on the frame where hold_cnt = HOLD_FRAMES-1, clear hold_cnt, go to RETRACT.
REQ-019 RETRACT: shift <= shift + STEP; when the new value equals SHIFT_MAX, go to EXTEND.
REQ-020 EXTEND: shift <= shift - STEP; when the new value equals 0, clear hold_cnt and go to HOLD.
REQ-021 shift SHALL saturate within 0..SHIFT_MAX; it never wraps.
REQ-022 A new shift value SHALL first affect color on the cycle after the frame_start edge that produced it.
REQ-023 frame_start asserted while rst is high SHALL be ignored.

Reset
REQ-024 On rst high, immediately and asynchronously: color = 0, state = HOLD, shift = 0, hold_cnt = 0.
REQ-025 Reset mid-animation (RETRACT or EXTEND) SHALL restart the sequence from HOLD with a full HOLD_FRAMES count.

Configuration
REQ-026 Macro FLAG_PROGRESS_CIRCLE_EN selects the inner-field rendering.
REQ-027 With FLAG_PROGRESS_CIRCLE_EN defined: cx = |pix_x - (70 - shift)| (signed), cy = |pix_y - 240|, r2 = cx*cx + cy*cy at 17 bits or wider; r2 < 2000 YELLOW, r2 < 3000 PURPLE, else YELLOW.
REQ-028 Without FLAG_PROGRESS_CIRCLE_EN: the inner field SHALL be solid YELLOW and no multipliers SHALL be synthesised.

Verification
REQ-029 Reset, then display_on = 1, pix_x = 0, pix_y = 240, no frame_start -> color = YELLOW one cycle later (circle edge r2 = 4900 or macro off).
REQ-030 shift = 0, pix_y = 0, pix_x = 30 -> PINK; pix_x = 250 -> rainbow RED; pix_y = 479, pix_x = 250 -> PURPLE.
REQ-031 With defaults, 120 frame_start pulses -> state RETRACT, shift still 0; next pulse -> shift = 2.
REQ-032 Continue 150 pulses -> shift = 300, state EXTEND; 150 more -> shift = 0, state HOLD, hold_cnt = 0.
REQ-033 Assert rst while shift = 100 in RETRACT -> color = 0 and shift = 0 immediately; after release, HOLD lasts a full 120 frames.
REQ-034 display_on low for any pix_x, pix_y -> color = 0 next cycle; with macro on, shift = 0, pix_x = 70, pix_y = 240 -> YELLOW; pix_x = 70, pix_y = 290 (r2 = 2500) -> PURPLE.
